// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// tx_arbiter : 4-requester round-robin arbiter in front of one UART transmitter
//              (optional BUSY watchdog via TX_ARB_TIMEOUT_EN).   Rev 1.0
// ============================================================================
module tx_arbiter #(
  parameter int          N       = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   i_req,
  input  logic [N-1:0] i_data0,
  input  logic [N-1:0] i_data1,
  input  logic [N-1:0] i_data2,
  input  logic [N-1:0] i_data3,
  input  logic         i_tx_done,
  output logic [N-1:0] o_tx,
  output logic         o_tx_start,
  output logic [3:0]   o_ack,
  output logic [1:0]   o_grant,
  output logic         o_busy,
  output logic         o_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    ACK   = 3'd3
`ifdef TX_ARB_TIMEOUT_EN
    , ABORT = 3'd4
`endif
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [1:0]   last_grant;
  logic [1:0]   winner;
  logic [1:0]   cand;
  logic [N-1:0] winner_data;
  logic         take_grant;
  logic         retire;

  // Scan from farthest to nearest so the first set bit after last_grant wins.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = last_grant + i[1:0];
      if (i_req[cand]) winner = cand;
    end
  end

  always_comb begin
    case (winner)
      2'd0:    winner_data = i_data0;
      2'd1:    winner_data = i_data1;
      2'd2:    winner_data = i_data2;
      default: winner_data = i_data3;
    endcase
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               tmo_cnt <= 16'd0;
    else if (state == BUSY) tmo_cnt <= tmo_cnt + 16'd1;
    else                    tmo_cnt <= 16'd0;
  end

  assign tmo_hit = (tmo_cnt == TIMEOUT - 16'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_nx   = state;
    take_grant = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req != 4'b0000) begin
          take_grant = 1'b1;
          state_nx   = START;
        end
      end
      START: state_nx = BUSY;
      BUSY: begin
        if (i_tx_done) state_nx = ACK;
`ifdef TX_ARB_TIMEOUT_EN
        else if (tmo_hit) state_nx = ABORT;
`endif
      end
      ACK: begin
        retire   = 1'b1;
        state_nx = IDLE;
      end
`ifdef TX_ARB_TIMEOUT_EN
      ABORT: begin
        retire   = 1'b1;
        state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      o_tx       <= '0;
      o_grant    <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state <= state_nx;
      if (take_grant) begin
        o_grant <= winner;
        o_tx    <= winner_data;
      end
      if (retire) last_grant <= o_grant;
    end
  end

  assign o_tx_start = (state == START);
  assign o_busy     = (state != IDLE);
  assign o_ack      = (state == ACK) ? (4'b0001 << o_grant) : 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
  assign o_timeout  = (state == ABORT);
`else
  assign o_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tx_arbiter : vector table, directed corner sequences and a randomized
//                 run against a timestamp-based transaction model.  Rev 1.0
// ============================================================================
module tb_tx_arbiter;
  localparam int N   = 8;
  localparam int INF = 1 << 30;

  logic         clk;
  logic         rst;
  logic [3:0]   i_req;
  logic [N-1:0] data [4];
  logic         i_tx_done;
  logic [N-1:0] o_tx;
  logic         o_tx_start;
  logic [3:0]   o_ack;
  logic [1:0]   o_grant;
  logic         o_busy;
  logic         o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tx_arbiter #(.N(N), .TIMEOUT(16'd20)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_data0   (data[0]),
    .i_data1   (data[1]),
    .i_data2   (data[2]),
    .i_data3   (data[3]),
    .i_tx_done (i_tx_done),
    .o_tx      (o_tx),
    .o_tx_start(o_tx_start),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  typedef struct {
    logic [3:0]   req;
    logic [1:0]   grant;
    logic [N-1:0] tx;
    int           delay;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed view {tx, start, ack, grant, busy, timeout}
  function automatic logic [31:0] snap();
    return 32'({o_tx, o_tx_start, o_ack, o_grant, o_busy, o_timeout});
  endfunction

  function automatic logic [31:0] mk(input logic [N-1:0] tx, input logic st, input logic [3:0] ak,
                                     input logic [1:0] gr, input logic bz, input logic to);
    return 32'({tx, st, ak, gr, bz, to});
  endfunction

  function automatic logic [1:0] rr_pick(input int last, input logic [3:0] rq);
    for (int i = 1; i <= 4; i++)
      if (rq[(last + i) % 4]) return 2'((last + i) % 4);
    return 2'd0;
  endfunction

  task automatic apply_reset(input int cycles);
    i_req     = 4'b0000;
    i_tx_done = 1'b0;
    rst       = 1'b0;
    #1;
    check("reset_values", snap(), mk('0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < cycles; i++) tick();
    check("reset_held", snap(), mk('0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    rst = 1'b1;
  endtask

  // Full transfer from an IDLE cycle: grant, `delay` BUSY cycles, done, ack, idle.
  task automatic run_txn(input string name, input logic [3:0] req, input int delay,
                         input logic [1:0] eg, input logic [N-1:0] etx);
    int bad;
    i_req = req;
    tick();
    check({name, "_start"}, snap(), mk(etx, 1'b1, 4'b0000, eg, 1'b1, 1'b0));
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (snap() !== mk(etx, 1'b0, 4'b0000, eg, 1'b1, 1'b0)) bad++;
    end
    check({name, "_busy"}, bad, 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check({name, "_ack"}, snap(), mk(etx, 1'b0, 4'b0001 << eg, eg, 1'b1, 1'b0));
    tick();
    check({name, "_idle"}, snap(), mk(etx, 1'b0, 4'b0000, eg, 1'b0, 1'b0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int last_m, gcyc, acyc, nfree;
    logic [1:0]   g_m;
    logic [N-1:0] tx_m;
    logic         have_m;

    vecs[0] = '{4'b1111, 2'd0, 8'h11, 3};
    vecs[1] = '{4'b1111, 2'd1, 8'h22, 1};
    vecs[2] = '{4'b1111, 2'd2, 8'h33, 4};
    vecs[3] = '{4'b1111, 2'd3, 8'h44, 2};
    vecs[4] = '{4'b1111, 2'd0, 8'h11, 5};
    vecs[5] = '{4'b1001, 2'd3, 8'h44, 1};
    vecs[6] = '{4'b0110, 2'd1, 8'h22, 2};
    vecs[7] = '{4'b0010, 2'd1, 8'h22, 3};
    vecs[8] = '{4'b0101, 2'd2, 8'h33, 1};
    vecs[9] = '{4'b0001, 2'd0, 8'h11, 2};

    for (int k = 0; k < 4; k++) data[k] = '0;

    // Single requester, done 10 cycles after start
    apply_reset(2);
    data[0] = 8'hA5;
    run_txn("single", 4'b0001, 10, 2'd0, 8'hA5);

    // Round-robin table
    apply_reset(2);
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    for (int r = 0; r < 10; r++)
      run_txn($sformatf("rr%0d", r), vecs[r].req, vecs[r].delay, vecs[r].grant, vecs[r].tx);

    // Data changes after grant must not reach o_tx
    data[2] = 8'h5A;
    i_req = 4'b0100;
    tick();
    check("hold_start", snap(), mk(8'h5A, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0));
    tick();
    data[2] = 8'hFF;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_tx !== 8'h5A) bad++;
    end
    check("hold_busy", bad, 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("hold_ack", snap(), mk(8'h5A, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
    i_req = 4'b0000;
    tick();
    check("hold_idle", snap(), mk(8'h5A, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));

    // Reset in the middle of BUSY abandons the transfer
    data[1] = 8'h77;
    i_req = 4'b0010;
    tick();
    tick();
    tick();
    apply_reset(2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      i_tx_done = (i == 0);
      if (snap() !== mk('0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0)) bad++;
      tick();
    end
    i_tx_done = 1'b0;
    check("rst_quiet", bad, 0);
    data[3] = 8'hC3;
    run_txn("post_rst", 4'b1000, 3, 2'd3, 8'hC3);

    data[0] = 8'h11; data[1] = 8'h22;
`ifdef TX_ARB_TIMEOUT_EN
    i_req = 4'b0001;
    tick();
    check("to_start", snap(), mk(8'h11, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (snap() !== mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0)) bad++;
    end
    check("to_wait", bad, 0);
    tick();
    check("to_pulse", snap(), mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1));
    i_req = 4'b0000;
    tick();
    check("to_idle", snap(), mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    run_txn("to_next", 4'b0011, 2, 2'd1, 8'h22);

    i_req = 4'b0001;
    tick();
    check("col_start", snap(), mk(8'h11, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0));
    for (int i = 0; i < 20; i++) tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("col_ack", snap(), mk(8'h11, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
    i_req = 4'b0000;
    tick();
    check("col_idle", snap(), mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
`else
    i_req = 4'b0001;
    tick();
    check("wait_start", snap(), mk(8'h11, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0));
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (snap() !== mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0)) bad++;
    end
    check("wait_forever", bad, 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("wait_ack", snap(), mk(8'h11, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
    i_req = 4'b0000;
    tick();
    check("wait_idle", snap(), mk(8'h11, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
`endif

    // Randomized traffic against a timestamp model: cycle c is the interval after edge c.
    apply_reset(2);
    for (int k = 0; k < 4; k++) data[k] = '0;
    last_m = 3; g_m = 2'd0; tx_m = '0; have_m = 1'b0;
    gcyc = 0; acyc = -1; nfree = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] eack;
      logic [3:0] rq;
      logic       ebusy, estart, dn;
      ebusy  = have_m && c >= gcyc && (acyc < 0 || c <= acyc);
      estart = have_m && c == gcyc;
      eack   = (have_m && c == acyc) ? (4'b0001 << g_m) : 4'b0000;
      check("rand_cycle", snap(), mk(tx_m, estart, eack, g_m, ebusy, 1'b0));

      rq = i_req;
      for (int k = 0; k < 4; k++) begin
        if (eack[k]) begin
          if ($urandom_range(1, 0) == 0) rq[k] = 1'b0;
          else data[k] = N'($urandom);
        end else if (!rq[k]) begin
          if ($urandom_range(3, 0) == 0) begin
            rq[k]   = 1'b1;
            data[k] = N'($urandom);
          end
        end else if (have_m && acyc < 0 && int'(g_m) == k) begin
          if ($urandom_range(3, 0) == 0) data[k] = N'($urandom);
        end else if ($urandom_range(15, 0) == 0) begin
          rq[k] = 1'b0;
        end
      end

      if (have_m && acyc < 0 && c >= gcyc + 1)
        dn = ($urandom_range(3, 0) == 0) || (c - gcyc >= 12);
      else
        dn = ($urandom_range(7, 0) == 0);

      i_req     = rq;
      i_tx_done = dn;

      if (c >= nfree && rq != 4'b0000) begin
        g_m    = rr_pick(last_m, rq);
        tx_m   = data[g_m];
        gcyc   = c + 1;
        acyc   = -1;
        have_m = 1'b1;
        nfree  = INF;
      end else if (have_m && acyc < 0 && c >= gcyc + 1 && dn) begin
        acyc   = c + 1;
        last_m = int'(g_m);
        nfree  = c + 2;
      end
      tick();
    end
    i_req     = 4'b0000;
    i_tx_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
